// File: rtl/id_stage_hs_if.sv
// id_stage_hs_if: fetch, write-back and execute-side signals of the decode stage
interface id_stage_hs_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            flush;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic            out_alu_src;
    logic            out_branch;
    logic            out_jump;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            out_mem_to_reg;
    logic            out_reg_write;
    logic            out_illegal;
    logic [1:0]      out_alu_op;

    modport master (
        output in_valid, in_pc, in_instr, flush, wb_we, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_rs1, out_rs2, out_rd, out_funct3, out_funct7, out_alu_src,
               out_branch, out_jump, out_mem_read, out_mem_write, out_mem_to_reg,
               out_reg_write, out_illegal, out_alu_op
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, wb_we, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_rs1, out_rs2, out_rd, out_funct3, out_funct7, out_alu_src,
               out_branch, out_jump, out_mem_read, out_mem_write, out_mem_to_reg,
               out_reg_write, out_illegal, out_alu_op
    );
endinterface

// File: rtl/id_stage_hs.sv
// id_stage_hs: RV32I/RV32E decode, register file and valid/ready ID/EX register; ID_STAGE_WB_BYPASS_EN adds write-back bypass
module id_stage_hs #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input logic          clk,
    input logic          reset,
    id_stage_hs_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            alu_src;
        logic [1:0]      alu_op;
        logic            branch;
        logic            jump;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_write;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0]   regs_q [NUM_REGS];
    logic [XLEN-1:0]   rs1_data, rs2_data;
    logic [31:0]       instr;
    logic [6:0]        opcode;
    logic [4:0]        rs1, rs2, rd;
    logic signed [31:0] imm32;
    logic              uses_rs1, uses_rs2, hazard, accept, consume;
    logic              valid_q, valid_d;
    entry_t            dec, entry_q, entry_d;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    // Combinational register reads; x0 and out-of-range indices read as zero
    always_comb begin
        rs1_data = (rs1 != 5'd0 && 32'(rs1) < NUM_REGS) ? regs_q[rs1[AW-1:0]] : '0;
        rs2_data = (rs2 != 5'd0 && 32'(rs2) < NUM_REGS) ? regs_q[rs2[AW-1:0]] : '0;
`ifdef ID_STAGE_WB_BYPASS_EN
        if (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == rs1) rs1_data = bus.wb_data;
        if (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == rs2) rs2_data = bus.wb_data;
`endif
    end

    // Decode the incoming instruction into a candidate ID/EX entry
    always_comb begin
        dec          = '0;
        dec.pc       = bus.in_pc;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = rd;
        dec.funct3   = instr[14:12];
        dec.funct7   = instr[31:25];
        imm32        = '0;
        case (opcode)
            OP_R:            {dec.alu_src, dec.alu_op, dec.branch, dec.jump, dec.mem_read, dec.mem_write, dec.mem_to_reg, dec.reg_write} = 9'b0_10_000001;
            OP_IALU:         {dec.alu_src, dec.alu_op, dec.branch, dec.jump, dec.mem_read, dec.mem_write, dec.mem_to_reg, dec.reg_write} = 9'b1_10_000001;
            OP_LOAD:         {dec.alu_src, dec.alu_op, dec.branch, dec.jump, dec.mem_read, dec.mem_write, dec.mem_to_reg, dec.reg_write} = 9'b1_00_001011;
            OP_STORE:        {dec.alu_src, dec.alu_op, dec.branch, dec.jump, dec.mem_read, dec.mem_write, dec.mem_to_reg, dec.reg_write} = 9'b1_00_000100;
            OP_BRANCH:       {dec.alu_src, dec.alu_op, dec.branch, dec.jump, dec.mem_read, dec.mem_write, dec.mem_to_reg, dec.reg_write} = 9'b0_01_100000;
            OP_JAL, OP_JALR: {dec.alu_src, dec.alu_op, dec.branch, dec.jump, dec.mem_read, dec.mem_write, dec.mem_to_reg, dec.reg_write} = 9'b1_00_010001;
            OP_LUI, OP_AUIPC:{dec.alu_src, dec.alu_op, dec.branch, dec.jump, dec.mem_read, dec.mem_write, dec.mem_to_reg, dec.reg_write} = 9'b1_11_000001;
            default:         dec.illegal = 1'b1;
        endcase
        case (opcode)
            OP_IALU, OP_LOAD, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:                  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:                 imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:          imm32 = {instr[31:12], 12'b0};
            OP_JAL:                    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:                   imm32 = '0;
        endcase
        dec.imm = XLEN'(imm32);
        if (32'(rs1) >= NUM_REGS || 32'(rs2) >= NUM_REGS || 32'(rd) >= NUM_REGS) begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
        end
    end

    assign uses_rs1 = opcode inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    assign uses_rs2 = opcode inside {OP_R, OP_STORE, OP_BRANCH};
    assign hazard   = valid_q && entry_q.mem_read && entry_q.rd != 5'd0 &&
                      ((entry_q.rd == rs1 && uses_rs1) || (entry_q.rd == rs2 && uses_rs2));
    assign bus.in_ready = !reset && !bus.flush && !hazard && (!valid_q || bus.out_ready);
    assign accept   = bus.in_valid && bus.in_ready;
    assign consume  = valid_q && bus.out_ready;
    assign valid_d  = bus.flush ? 1'b0 : accept ? 1'b1 : consume ? 1'b0 : valid_q;
    assign entry_d  = accept ? dec : entry_q;

    // ID/EX pipeline register; holds its entry until replaced by an accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    // Register file write port; x0 and out-of-range indices are never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (bus.wb_we && bus.wb_rd != 5'd0 && 32'(bus.wb_rd) < NUM_REGS) begin
            regs_q[bus.wb_rd[AW-1:0]] <= bus.wb_data;
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_pc         = entry_q.pc;
    assign bus.out_rs1_data   = entry_q.rs1_data;
    assign bus.out_rs2_data   = entry_q.rs2_data;
    assign bus.out_imm        = entry_q.imm;
    assign bus.out_rs1        = entry_q.rs1;
    assign bus.out_rs2        = entry_q.rs2;
    assign bus.out_rd         = entry_q.rd;
    assign bus.out_funct3     = entry_q.funct3;
    assign bus.out_funct7     = entry_q.funct7;
    assign bus.out_alu_src    = entry_q.alu_src;
    assign bus.out_alu_op     = entry_q.alu_op;
    assign bus.out_branch     = entry_q.branch;
    assign bus.out_jump       = entry_q.jump;
    assign bus.out_mem_read   = entry_q.mem_read;
    assign bus.out_mem_write  = entry_q.mem_write;
    assign bus.out_mem_to_reg = entry_q.mem_to_reg;
    assign bus.out_reg_write  = entry_q.reg_write;
    assign bus.out_illegal    = entry_q.illegal;
endmodule

// File: tb/tb_id_stage_hs.sv
// tb_id_stage_hs: directed self-checking bench for the decode stage
module tb_id_stage_hs;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

`ifdef ID_STAGE_WB_BYPASS_EN
    localparam logic [31:0] BYP = 32'hDEADBEEF;
`else
    localparam logic [31:0] BYP = 32'h0;
`endif

    id_stage_hs_if #(.XLEN(32)) bus ();
    id_stage_hs #(.XLEN(32), .NUM_REGS(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = instr;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.flush = 1'b0;
        bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        reset = 1'b0;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h55;
        tick();
        bus.wb_rd = 5'd0; bus.wb_data = 32'h99;
        tick();
        bus.wb_we = 1'b0;
        drive(32'h100, 32'h00500093);
        chk("addi_in_ready", 32'(bus.in_ready), 1);
        tick();
        chk("addi_valid", 32'(bus.out_valid), 1);
        chk("addi_imm", bus.out_imm, 5);
        chk("addi_alu_src", 32'(bus.out_alu_src), 1);
        chk("addi_alu_op", 32'(bus.out_alu_op), 2);
        chk("addi_reg_write", 32'(bus.out_reg_write), 1);
        chk("addi_rd", 32'(bus.out_rd), 1);
        chk("addi_pc", bus.out_pc, 32'h100);
        chk("x0_write_ignored", bus.out_rs1_data, 0);
        chk("flow_in_ready", 32'(bus.in_ready), 1);
        drive(32'h104, 32'h00028333);
        tick();
        chk("add_rs1_data", bus.out_rs1_data, 32'h55);
        chk("add_rd", 32'(bus.out_rd), 6);
        chk("add_alu_src", 32'(bus.out_alu_src), 0);
        chk("add_imm", bus.out_imm, 0);
        bus.out_ready = 1'b0;
        drive(32'h108, 32'h0000A103);
        chk("bp_in_ready", 32'(bus.in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_pc_frozen", bus.out_pc, 32'h104);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_in_ready_low", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 1);
        tick();
        chk("lw_pc", bus.out_pc, 32'h108);
        chk("lw_mem_read", 32'(bus.out_mem_read), 1);
        chk("lw_mem_to_reg", 32'(bus.out_mem_to_reg), 1);
        chk("lw_rd", 32'(bus.out_rd), 2);
        chk("lw_alu_op", 32'(bus.out_alu_op), 0);
        drive(32'h10C, 32'h002101B3);
        chk("hazard_in_ready", 32'(bus.in_ready), 0);
        tick();
        chk("bubble_valid", 32'(bus.out_valid), 0);
        chk("bubble_in_ready", 32'(bus.in_ready), 1);
        tick();
        chk("after_bubble_valid", 32'(bus.out_valid), 1);
        chk("after_bubble_pc", bus.out_pc, 32'h10C);
        chk("after_bubble_rs2", 32'(bus.out_rs2), 2);
        bus.flush = 1'b1;
        drive(32'h110, 32'h00208463);
        chk("flush_in_ready", 32'(bus.in_ready), 0);
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("flush_valid", 32'(bus.out_valid), 0);
        chk("flush_no_beq", 32'(bus.out_branch), 0);
        tick();
        chk("flush_idle_valid", 32'(bus.out_valid), 0);
        drive(32'h114, 32'h00208463);
        tick();
        chk("beq_branch", 32'(bus.out_branch), 1);
        chk("beq_alu_op", 32'(bus.out_alu_op), 1);
        chk("beq_imm", bus.out_imm, 8);
        chk("beq_reg_write", 32'(bus.out_reg_write), 0);
        drive(32'h118, 32'hFE20AE23);
        tick();
        chk("sw_imm", bus.out_imm, 32'hFFFFFFFC);
        chk("sw_mem_write", 32'(bus.out_mem_write), 1);
        chk("sw_reg_write", 32'(bus.out_reg_write), 0);
        drive(32'h11C, 32'h123450B7);
        tick();
        chk("lui_imm", bus.out_imm, 32'h12345000);
        chk("lui_alu_op", 32'(bus.out_alu_op), 3);
        drive(32'h120, 32'hFFF00093);
        tick();
        chk("addi_neg_imm", bus.out_imm, 32'hFFFFFFFF);
        drive(32'h124, 32'h008000EF);
        tick();
        chk("jal_jump", 32'(bus.out_jump), 1);
        chk("jal_imm", bus.out_imm, 8);
        chk("jal_reg_write", 32'(bus.out_reg_write), 1);
        drive(32'h128, 32'h0000007F);
        tick();
        chk("illegal_flag", 32'(bus.out_illegal), 1);
        chk("illegal_reg_write", 32'(bus.out_reg_write), 0);
        chk("illegal_alu_src", 32'(bus.out_alu_src), 0);
        bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hDEADBEEF;
        drive(32'h12C, 32'h00018233);
        tick();
        bus.wb_we = 1'b0;
        chk("bypass_rs1_data", bus.out_rs1_data, BYP);
        drive(32'h130, 32'h00018233);
        tick();
        chk("x3_written", bus.out_rs1_data, 32'hDEADBEEF);
        drive(32'h134, 32'h00500093);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_pc", bus.out_pc, 0);
        chk("mid_rst_rs1_data", bus.out_rs1_data, 0);
        chk("mid_rst_imm", bus.out_imm, 0);
        chk("mid_rst_rd", 32'(bus.out_rd), 0);
        chk("mid_rst_reg_write", 32'(bus.out_reg_write), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        tick();
        reset = 1'b0;
        drive(32'h138, 32'h00028333);
        tick();
        chk("post_rst_valid", 32'(bus.out_valid), 1);
        chk("post_rst_x5", bus.out_rs1_data, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
